// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared encodings for the RV32I pipeline. Holds the EX ALU
//               control constants, the operand-select constants, the opcodes
//               and the immediate-format enum. It also provides the packed
//               ID/EX record and a funct3-to-ALU helper.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // ALUctr encodings seen by the EX stage
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  // ALU operand selects
  localparam logic       ASRC_BUSA = 1'b0;
  localparam logic       ASRC_PC   = 1'b1;
  localparam logic [1:0] BSRC_REG  = 2'b00;
  localparam logic [1:0] BSRC_FOUR = 2'b01;
  localparam logic [1:0] BSRC_IMM  = 2'b10;

  // Major opcodes of the supported subset
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Contents of the ID/EX register; all-zero is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_ctr;
    logic        alu_asrc;
    logic [1:0]  alu_bsrc;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ex_t;

  // Shared by R-type and I-ALU: {supported, ALUctr} for a funct3 value.
  function automatic logic [4:0] alu_sel(input logic [2:0] funct3);
    case (funct3)
      3'b000:  alu_sel = {1'b1, ALU_ADD};
      3'b110:  alu_sel = {1'b1, ALU_OR};
      3'b010:  alu_sel = {1'b1, ALU_SLT};
      3'b011:  alu_sel = {1'b1, ALU_SLTU};
      default: alu_sel = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : id_imm_gen
// Description : Combinational immediate generator. Every format is
//               sign-extended from instr[31]; IMM_NONE yields zero.
// Ports       : instr  in  instruction bits [31:7] (opcode not needed)
//               fmt    in  immediate format
//               imm    out 32-bit immediate
// Revision    : 1.0  initial release
// ============================================================================
module id_imm_gen
  import pipe_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_decode_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_decode_reg
// Description : RV32I decode stage plus ID/EX pipeline register. Decodes the
//               IF/ID instruction into EX ALU controls and MEM/WB controls,
//               detects load-use hazards and applies flush/stall.
// Ports       : clk, rst (sync, active high)
//               id_valid/id_pc/id_instr/id_busA/id_busB  IF/ID inputs
//               stall (hold), flush (kill)
//               rs1_idx, rs2_idx, load_use_stall         combinational
//               ex_*                                     registered EX fields
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_decode_reg
  import pipe_pkg::*;
#(
  parameter int XLEN           = 32,   // only 32 is supported
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_busA,
  input  logic [XLEN-1:0] id_busB,
  input  logic            stall,
  input  logic            flush,
  output logic [4:0]      rs1_idx,
  output logic [4:0]      rs2_idx,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [3:0]      ex_ALUctr,
  output logic            ex_ALUASrc,
  output logic [1:0]      ex_ALUBSrc,
  output logic [XLEN-1:0] ex_busA,
  output logic [XLEN-1:0] ex_busB,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_RegWr,
  output logic            ex_MemWr,
  output logic            ex_MemtoReg,
  output logic            ex_Branch,
  output logic            ex_Jump,
  output logic            ex_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [4:0]  f3_sel;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign funct7 = id_instr[31:25];
  assign f3_sel = alu_sel(funct3);

  logic       dec_legal, dec_lui, dec_use_rs1, dec_use_rs2;
  logic [3:0] dec_ctr;
  logic       dec_asrc;
  logic [1:0] dec_bsrc;
  logic       dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump;
  imm_fmt_e   dec_fmt;
  logic [31:0] dec_imm;

  always_comb begin
    dec_legal    = 1'b0;
    dec_lui      = 1'b0;
    dec_use_rs1  = 1'b0;
    dec_use_rs2  = 1'b0;
    dec_ctr      = ALU_ADD;
    dec_asrc     = ASRC_BUSA;
    dec_bsrc     = BSRC_REG;
    dec_regwr    = 1'b0;
    dec_memwr    = 1'b0;
    dec_memtoreg = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_fmt      = IMM_NONE;
    case (opcode)
      OP_R: begin
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_regwr   = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_legal = f3_sel[4];
          dec_ctr   = f3_sel[3:0];
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_ctr   = ALU_SUB;
        end
      end
      OP_IMM: begin
        dec_legal   = f3_sel[4];
        dec_ctr     = f3_sel[3:0];
        dec_use_rs1 = 1'b1;
        dec_regwr   = 1'b1;
        dec_bsrc    = BSRC_IMM;
        dec_fmt     = IMM_I;
      end
      OP_LOAD: begin
        dec_legal    = (funct3 == 3'b010);
        dec_use_rs1  = 1'b1;
        dec_regwr    = 1'b1;
        dec_memtoreg = 1'b1;
        dec_bsrc     = BSRC_IMM;
        dec_fmt      = IMM_I;
      end
      OP_STORE: begin
        dec_legal   = (funct3 == 3'b010);
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_memwr   = 1'b1;
        dec_bsrc    = BSRC_IMM;
        dec_fmt     = IMM_S;
      end
      OP_BRANCH: begin
        dec_legal   = (funct3 == 3'b000);
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_ctr     = ALU_SUB;
        dec_branch  = 1'b1;
        dec_fmt     = IMM_B;
      end
      OP_JAL: begin
        dec_legal = 1'b1;
        dec_asrc  = ASRC_PC;
        dec_bsrc  = BSRC_FOUR;
        dec_jump  = 1'b1;
        dec_regwr = 1'b1;
        dec_fmt   = IMM_J;
      end
      OP_JALR: begin
        // ALU produces the link value PC+4; the target busA+imm is formed in EX.
        dec_legal   = (funct3 == 3'b000);
        dec_use_rs1 = 1'b1;
        dec_asrc    = ASRC_PC;
        dec_bsrc    = BSRC_FOUR;
        dec_jump    = 1'b1;
        dec_regwr   = 1'b1;
        dec_fmt     = IMM_I;
      end
      OP_LUI: begin
        // Computed as 0 + imm, so busA is forced to zero.
        dec_legal = 1'b1;
        dec_lui   = 1'b1;
        dec_bsrc  = BSRC_IMM;
        dec_regwr = 1'b1;
        dec_fmt   = IMM_U;
      end
      OP_AUIPC: begin
        dec_legal = 1'b1;
        dec_asrc  = ASRC_PC;
        dec_bsrc  = BSRC_IMM;
        dec_regwr = 1'b1;
        dec_fmt   = IMM_U;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  id_imm_gen u_imm_gen (
    .instr (id_instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  id_ex_t ex_state;
  id_ex_t ex_next;

  assign rs1_idx = dec_lui ? 5'd0 : rs1;
  assign rs2_idx = rs2;

  // Depends only on the current ID/EX contents and the IF/ID instruction.
  assign load_use_stall = ex_state.valid && ex_state.mem_to_reg && (ex_state.rd != 5'd0) &&
                          id_valid && dec_legal &&
                          ((dec_use_rs1 && (ex_state.rd == rs1)) ||
                           (dec_use_rs2 && (ex_state.rd == rs2)));

  always_comb begin
    ex_next = '0;
    if (id_valid && dec_legal) begin
      ex_next.valid      = 1'b1;
      ex_next.pc         = id_pc;
      ex_next.alu_ctr    = dec_ctr;
      ex_next.alu_asrc   = dec_asrc;
      ex_next.alu_bsrc   = dec_bsrc;
      ex_next.bus_a      = dec_lui ? '0 : id_busA;
      ex_next.bus_b      = id_busB;
      ex_next.imm        = dec_imm;
      ex_next.reg_wr     = dec_regwr && (rd != 5'd0);
      ex_next.rd         = (dec_regwr && (rd != 5'd0)) ? rd : 5'd0;
      ex_next.mem_wr     = dec_memwr;
      ex_next.mem_to_reg = dec_memtoreg;
      ex_next.branch     = dec_branch;
      ex_next.jump       = dec_jump;
    end else if (id_valid && ILLEGAL_AS_NOP) begin
      // Bubble that remembers where the bad instruction came from.
      ex_next.illegal = 1'b1;
      ex_next.pc      = id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_state <= '0;
    end else if (flush) begin
      ex_state <= '0;
    end else if (load_use_stall) begin
      ex_state <= '0;
    end else if (!stall) begin
      ex_state <= ex_next;
    end
  end

  assign ex_valid    = ex_state.valid;
  assign ex_pc       = ex_state.pc;
  assign ex_ALUctr   = ex_state.alu_ctr;
  assign ex_ALUASrc  = ex_state.alu_asrc;
  assign ex_ALUBSrc  = ex_state.alu_bsrc;
  assign ex_busA     = ex_state.bus_a;
  assign ex_busB     = ex_state.bus_b;
  assign ex_imm      = ex_state.imm;
  assign ex_rd       = ex_state.rd;
  assign ex_RegWr    = ex_state.reg_wr;
  assign ex_MemWr    = ex_state.mem_wr;
  assign ex_MemtoReg = ex_state.mem_to_reg;
  assign ex_Branch   = ex_state.branch;
  assign ex_Jump     = ex_state.jump;
  assign ex_illegal  = ex_state.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_decode_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_decode_reg
// Description : Self-checking bench for id_ex_decode_reg. A mask/match
//               instruction table and arithmetic immediates form the reference
//               model; directed literals pin the model, then random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_decode_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  ctr;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regwr;
    logic        memwr;
    logic        memtoreg;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ex_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  ctr;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [4:0]  flags;   // {regwr, memwr, memtoreg, branch, jump}
    int          fmt;
    logic        use1;
    logic        use2;
    logic        lui;
  } dec_t;

  localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;
  localparam int NENT = 16;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_pc, id_instr, id_busA, id_busB;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        load_use_stall;
  logic        ex_valid, ex_ALUASrc, ex_RegWr, ex_MemWr, ex_MemtoReg, ex_Branch, ex_Jump, ex_illegal;
  logic [31:0] ex_pc, ex_busA, ex_busB, ex_imm;
  logic [3:0]  ex_ALUctr;
  logic [1:0]  ex_ALUBSrc;
  logic [4:0]  ex_rd;

  id_ex_decode_reg #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_busA(id_busA), .id_busB(id_busB), .stall(stall), .flush(flush),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ALUctr(ex_ALUctr), .ex_ALUASrc(ex_ALUASrc),
    .ex_ALUBSrc(ex_ALUBSrc), .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  ex_t dut_ex;
  assign dut_ex = {ex_valid, ex_pc, ex_ALUctr, ex_ALUASrc, ex_ALUBSrc, ex_busA, ex_busB,
                   ex_imm, ex_rd, ex_RegWr, ex_MemWr, ex_MemtoReg, ex_Branch, ex_Jump, ex_illegal};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic dec_t mk(input logic [31:0] mask, input logic [31:0] match,
                              input logic [3:0] ctr, input logic asrc, input logic [1:0] bsrc,
                              input logic [4:0] flags, input int fmt,
                              input logic use1, input logic use2, input logic lui);
    dec_t d;
    d.mask = mask; d.match = match; d.ctr = ctr; d.asrc = asrc; d.bsrc = bsrc;
    d.flags = flags; d.fmt = fmt; d.use1 = use1; d.use2 = use2; d.lui = lui;
    return d;
  endfunction

  function automatic dec_t entry(input int i);
    case (i)
      0:  return mk(32'hFE00707F, 32'h00000033, 4'b0000, 1'b0, 2'b00, 5'b10000, F_NONE, 1, 1, 0); // add
      1:  return mk(32'hFE00707F, 32'h40000033, 4'b1000, 1'b0, 2'b00, 5'b10000, F_NONE, 1, 1, 0); // sub
      2:  return mk(32'hFE00707F, 32'h00006033, 4'b0110, 1'b0, 2'b00, 5'b10000, F_NONE, 1, 1, 0); // or
      3:  return mk(32'hFE00707F, 32'h00002033, 4'b0010, 1'b0, 2'b00, 5'b10000, F_NONE, 1, 1, 0); // slt
      4:  return mk(32'hFE00707F, 32'h00003033, 4'b0011, 1'b0, 2'b00, 5'b10000, F_NONE, 1, 1, 0); // sltu
      5:  return mk(32'h0000707F, 32'h00000013, 4'b0000, 1'b0, 2'b10, 5'b10000, F_I, 1, 0, 0);    // addi
      6:  return mk(32'h0000707F, 32'h00002013, 4'b0010, 1'b0, 2'b10, 5'b10000, F_I, 1, 0, 0);    // slti
      7:  return mk(32'h0000707F, 32'h00003013, 4'b0011, 1'b0, 2'b10, 5'b10000, F_I, 1, 0, 0);    // sltiu
      8:  return mk(32'h0000707F, 32'h00006013, 4'b0110, 1'b0, 2'b10, 5'b10000, F_I, 1, 0, 0);    // ori
      9:  return mk(32'h0000707F, 32'h00002003, 4'b0000, 1'b0, 2'b10, 5'b10100, F_I, 1, 0, 0);    // lw
      10: return mk(32'h0000707F, 32'h00002023, 4'b0000, 1'b0, 2'b10, 5'b01000, F_S, 1, 1, 0);    // sw
      11: return mk(32'h0000707F, 32'h00000063, 4'b1000, 1'b0, 2'b00, 5'b00010, F_B, 1, 1, 0);    // beq
      12: return mk(32'h0000707F, 32'h00000067, 4'b0000, 1'b1, 2'b01, 5'b10001, F_I, 1, 0, 0);    // jalr
      13: return mk(32'h0000007F, 32'h0000006F, 4'b0000, 1'b1, 2'b01, 5'b10001, F_J, 0, 0, 0);    // jal
      14: return mk(32'h0000007F, 32'h00000037, 4'b0000, 1'b0, 2'b10, 5'b10000, F_U, 0, 0, 1);    // lui
      default: return mk(32'h0000007F, 32'h00000017, 4'b0000, 1'b1, 2'b10, 5'b10000, F_U, 0, 0, 0); // auipc
    endcase
  endfunction

  function automatic bit lookup(input logic [31:0] ins, output dec_t e);
    dec_t t;
    lookup = 1'b0;
    e = entry(0);
    for (int i = 0; i < NENT; i++) begin
      t = entry(i);
      if ((ins & t.mask) == t.match) begin
        e = t;
        lookup = 1'b1;
      end
    end
  endfunction

  // Immediates from weighted bit-fields; the sign bit carries a negative weight.
  function automatic logic [31:0] imm_of(input int fmt, input logic [31:0] ins);
    int v;
    case (fmt)
      F_I: v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
      F_S: v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
      F_B: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
      F_U: v = int'(ins & 32'hFFFFF000);
      F_J: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic ex_t model_load(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] a, input logic [31:0] b);
    ex_t  n;
    dec_t e;
    n = '0;
    if (!v) return n;
    if (!lookup(ins, e)) begin
      n.illegal = 1'b1;
      n.pc      = pc;
      return n;
    end
    n.valid    = 1'b1;
    n.pc       = pc;
    n.ctr      = e.ctr;
    n.asrc     = e.asrc;
    n.bsrc     = e.bsrc;
    n.a        = e.lui ? 32'd0 : a;
    n.b        = b;
    n.imm      = imm_of(e.fmt, ins);
    n.regwr    = e.flags[4] && (ins[11:7] != 5'd0);
    n.rd       = n.regwr ? ins[11:7] : 5'd0;
    n.memwr    = e.flags[3];
    n.memtoreg = e.flags[2];
    n.branch   = e.flags[1];
    n.jump     = e.flags[0];
    return n;
  endfunction

  function automatic logic model_lus(input ex_t ms, input logic v, input logic [31:0] ins);
    dec_t e;
    if (!v || !ms.valid || !ms.memtoreg || ms.rd == 5'd0) return 1'b0;
    if (!lookup(ins, e)) return 1'b0;
    return (e.use1 && ins[19:15] == ms.rd) || (e.use2 && ins[24:20] == ms.rd);
  endfunction

  function automatic logic [4:0] model_rs1(input logic [31:0] ins);
    dec_t e;
    if (lookup(ins, e) && e.lui) return 5'd0;
    return ins[19:15];
  endfunction

  ex_t m_state = '0;
  logic started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst || flush || model_lus(m_state, id_valid, id_instr))
      m_state <= '0;
    else if (!stall)
      m_state <= model_load(id_valid, id_pc, id_instr, id_busA, id_busB);
  end

  always @(negedge clk) begin
    if (started) begin
      check("ex_regs", 160'(dut_ex), 160'(m_state));
      check("comb_out", 160'({rs1_idx, rs2_idx, load_use_stall}),
            160'({model_rs1(id_instr), id_instr[24:20], model_lus(m_state, id_valid, id_instr)}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    dec_t e;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    e = entry(int'($urandom_range(0, NENT - 1)));
    r = (r & ~e.mask) | e.match;
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  logic hold;

  initial begin
    rst = 1'b1; id_valid = 1'b1; id_pc = 32'h0; id_instr = 32'h002081B3;
    id_busA = 32'd5; id_busB = 32'd7; stall = 1'b0; flush = 1'b0;
    step(); step();
    check("reset_all_zero", 160'(dut_ex), 160'(0));
    rst = 1'b0;
    step();                                        // add x3,x1,x2
    check("add_ctr_src", 160'({ex_ALUctr, ex_ALUASrc, ex_ALUBSrc}), 160'(7'b0000_0_00));
    check("add_bus", 160'({ex_busA, ex_busB}), 160'({32'd5, 32'd7}));
    check("add_rd_wr", 160'({ex_valid, ex_rd, ex_RegWr}), 160'({1'b1, 5'd3, 1'b1}));
    id_instr = 32'h00208033;                       // add x0,x1,x2
    step();
    check("add_x0_nowr", 160'({ex_valid, ex_rd, ex_RegWr}), 160'({1'b1, 5'd0, 1'b0}));
    id_instr = 32'hFFF00293;                       // addi x5,x0,-1
    step();
    check("addi_imm", 160'({ex_imm, ex_ALUBSrc, ex_rd}), 160'({32'hFFFFFFFF, 2'b10, 5'd5}));
    id_instr = 32'h008000EF; id_pc = 32'h100;      // jal x1,+8
    step();
    check("jal", 160'({ex_ALUASrc, ex_ALUBSrc, ex_imm, ex_Jump, ex_pc}),
          160'({1'b1, 2'b01, 32'd8, 1'b1, 32'h100}));
    id_instr = 32'h0000A303; id_pc = 32'h104;      // lw x6,0(x1)
    step();
    id_instr = 32'h002303B3; id_pc = 32'h108;      // add x7,x6,x2
    #1;
    check("lus_raised", 160'(load_use_stall), 160'(1));
    step();
    check("lus_bubble", 160'({ex_valid, load_use_stall}), 160'(0));
    step();
    check("add_after_lus", 160'({ex_valid, ex_rd, ex_pc}), 160'({1'b1, 5'd7, 32'h108}));
    id_instr = 32'h00500313;                       // addi x6,x0,5
    step();
    stall = 1'b1; id_instr = 32'hFFF00293;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 160'({ex_imm, ex_rd, ex_valid}), 160'({32'd5, 5'd6, 1'b1}));
    end
    flush = 1'b1;
    step();
    check("flush_over_stall", 160'({ex_valid, ex_RegWr, ex_imm}), 160'(0));
    flush = 1'b0; stall = 1'b0;
    id_instr = 32'h0000007F; id_pc = 32'h200;
    step();
    check("illegal", 160'({ex_illegal, ex_valid, ex_RegWr, ex_pc}), 160'({3'b100, 32'h200}));

    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        id_valid = ($urandom_range(0, 99) < 85);
        id_pc    = $urandom & 32'hFFFFFFFC;
        id_instr = rand_instr();
        id_busA  = $urandom;
        id_busB  = $urandom;
      end
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 99) < 5);
      stall = ($urandom_range(0, 99) < 10);
      #2;
      hold = (model_lus(m_state, id_valid, id_instr) || stall) && !flush && !rst;
      step();
    end
    #6;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
